// File: rtl/mem_resp_unit.sv
// Word-addressed memory responder for the core's fetch and load/store channels.
// Build option: define MEM_RESP_RAND_LAT_EN to add 0..7 LFSR-driven cycles to each read latency.
module mem_resp_unit #(
    parameter int         ADDR_WIDTH = 12,
    parameter int         LATENCY    = 2,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ack,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ack,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ack,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ack
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        I_WAIT,
        I_RESP,
        D_WAIT,
        D_RESP
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [CNT_W-1:0]      lat_load;
    logic [ADDR_WIDTH-1:0] idx_p0, idx_nxt;
    logic [31:0]           mem [DEPTH];
    logic                  data_req;
    logic                  store_go;
    logic                  rd_fire;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{PC[31:ADDR_WIDTH+2], PC[1:0],
                                Address[31:ADDR_WIDTH+2], Address[1:0]};

`ifdef MEM_RESP_RAND_LAT_EN
    logic [7:0] lfsr;
    logic       lfsr_fb;

    // Fibonacci taps 8,6,5,4
    assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign lat_load = CNT_W'(LATENCY) + CNT_W'(lfsr[2:0]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end
`else
    logic unused_seed;
    assign unused_seed = ^LFSR_SEED;
    assign lat_load    = CNT_W'(LATENCY);
`endif

    assign data_req        = MemRead | MemWrite;
    assign Inst_Valid      = (state == I_RESP);
    assign Read_data_Valid = (state == D_RESP);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        idx_nxt      = idx_p0;
        Inst_Req_Ack = 1'b0;
        Mem_Req_Ack  = 1'b0;
        store_go     = 1'b0;
        rd_fire      = 1'b0;
        case (state)
            IDLE: begin
                if (rst) begin
                    // data channel wins; a losing fetch simply stays un-acked
                    if (data_req) begin
                        Mem_Req_Ack = 1'b1;
                        if (MemWrite) begin
                            store_go = 1'b1;
                        end else begin
                            idx_nxt   = Address[ADDR_WIDTH+1:2];
                            cnt_nxt   = lat_load;
                            state_nxt = D_WAIT;
                        end
                    end else if (Inst_Req_Valid) begin
                        Inst_Req_Ack = 1'b1;
                        idx_nxt      = PC[ADDR_WIDTH+1:2];
                        cnt_nxt      = lat_load;
                        state_nxt    = I_WAIT;
                    end
                end
            end
            I_WAIT, D_WAIT: begin
                if (cnt == '0) begin
                    rd_fire   = 1'b1;
                    state_nxt = (state == I_WAIT) ? I_RESP : D_RESP;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            I_RESP: begin
                if (Inst_Ack) state_nxt = IDLE;
            end
            D_RESP: begin
                if (Read_data_Ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            Instruction <= '0;
            Read_data   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (rd_fire && state == I_WAIT) Instruction <= mem[idx_p0];
            if (rd_fire && state == D_WAIT) Read_data   <= mem[idx_p0];
        end
    end

    // p0: latched word index of the outstanding read
    always_ff @(posedge clk) begin
        idx_p0 <= idx_nxt;
    end

    always_ff @(posedge clk) begin
        if (store_go) begin
            for (int b = 0; b < 4; b++) begin
                if (Write_strb[b]) begin
                    mem[Address[ADDR_WIDTH+1:2]][8*b +: 8] <= Write_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_resp_unit.sv
// Directed checks of mem_resp_unit: reset, fetch/load latency, strobes, backpressure,
// channel priority, address wrap, mid-transaction reset and (optionally) random latency.
module tb_mem_resp_unit;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ack;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ack;
    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ack;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_resp_unit #(.ADDR_WIDTH(12), .LATENCY(LAT), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .rst(rst),
        .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ack(Inst_Req_Ack),
        .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ack(Inst_Ack),
        .Address(Address), .MemWrite(MemWrite), .Write_data(Write_data),
        .Write_strb(Write_strb), .MemRead(MemRead), .Mem_Req_Ack(Mem_Req_Ack),
        .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
        .Read_data_Ack(Read_data_Ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n = edges from the request cycle until valid is seen (acceptance edge is 1)
    task automatic wait_valid(input bit inst, output int n);
        n = 1;
        while (!(inst ? Inst_Valid : Read_data_Valid) && n < 64) begin
            tick();
            n++;
        end
        chk("resp_timeout", inst ? Inst_Valid : Read_data_Valid, 1);
    endtask

    task automatic lat_chk(input string tag, input int n);
`ifdef MEM_RESP_RAND_LAT_EN
        chk(tag, (n - 2 >= LAT && n - 2 <= LAT + 7), 1);
`else
        chk(tag, n, LAT + 2);
`endif
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input string tag);
        Address = addr; Write_data = data; Write_strb = strb; MemWrite = 1'b1;
        @(negedge clk);
        chk({tag, "_ack"}, Mem_Req_Ack, 1);
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [31:0] exp,
                           input int hold, input string tag);
        int n;
        Address = addr; MemRead = 1'b1;
        @(negedge clk);
        chk({tag, "_ack"}, Mem_Req_Ack, 1);
        tick();
        MemRead = 1'b0;
        wait_valid(0, n);
        lat_chk({tag, "_lat"}, n);
        chk({tag, "_data"}, Read_data, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_vld"}, Read_data_Valid, 1);
            chk({tag, "_hold_data"}, Read_data, exp);
        end
        Read_data_Ack = 1'b1;
        tick();
        Read_data_Ack = 1'b0;
        chk({tag, "_drop"}, Read_data_Valid, 0);
    endtask

    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] exp,
                            input int hold, input string tag);
        int n;
        PC = pc; Inst_Req_Valid = 1'b1;
        @(negedge clk);
        chk({tag, "_ack"}, Inst_Req_Ack, 1);
        tick();
        Inst_Req_Valid = 1'b0;
        wait_valid(1, n);
        lat_chk({tag, "_lat"}, n);
        chk({tag, "_data"}, Instruction, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_vld"}, Inst_Valid, 1);
            chk({tag, "_hold_data"}, Instruction, exp);
        end
        Inst_Ack = 1'b1;
        tick();
        Inst_Ack = 1'b0;
        chk({tag, "_drop"}, Inst_Valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int vld_seen;
        rst = 1'b0; PC = '0; Inst_Req_Valid = 1'b1; Inst_Ack = 1'b0;
        Address = '0; MemWrite = 1'b0; Write_data = '0; Write_strb = '0;
        MemRead = 1'b1; Read_data_Ack = 1'b0;

        // reset: requests present but acks must stay low
        repeat (3) tick();
        @(negedge clk);
        chk("rst_iack", Inst_Req_Ack, 0);
        chk("rst_mack", Mem_Req_Ack, 0);
        chk("rst_ivld", Inst_Valid, 0);
        chk("rst_dvld", Read_data_Valid, 0);
        chk("rst_inst", Instruction, 32'h0);
        chk("rst_rdata", Read_data, 32'h0);
        Inst_Req_Valid = 1'b0; MemRead = 1'b0;
        tick();
        rst = 1'b1;

        // stray Inst_Ack in IDLE is ignored
        Inst_Ack = 1'b1;
        tick();
        chk("idle_iack_ignored", Inst_Valid, 0);
        Inst_Ack = 1'b0;

        // preload and first fetch, response held while Inst_Ack low
        do_store(32'h0, 32'h00000013, 4'hF, "pre");
        do_fetch(32'h0, 32'h00000013, 2, "fetch0");

        // byte strobes
        do_store(32'h100, 32'hAABBCCDD, 4'b1111, "st_full");
        do_store(32'h100, 32'h11111111, 4'b0100, "st_b2");
        do_store(32'h100, 32'hFFFFFFFF, 4'b0000, "st_none");
        do_load(32'h100, 32'hAA11CCDD, 0, "ld_strb");

        // backpressure: 5 cycles without Read_data_Ack
        do_load(32'h100, 32'hAA11CCDD, 5, "ld_bp");

        // simultaneous requests: data first, fetch after
        do_store(32'h200, 32'hDEADBEEF, 4'hF, "st_sim");
        Address = 32'h200; MemRead = 1'b1; PC = 32'h0; Inst_Req_Valid = 1'b1;
        @(negedge clk);
        chk("sim_mack", Mem_Req_Ack, 1);
        chk("sim_iack", Inst_Req_Ack, 0);
        tick();
        MemRead = 1'b0;
        @(negedge clk);
        chk("sim_iack_wait", Inst_Req_Ack, 0);
        wait_valid(0, n);
        chk("sim_ld_data", Read_data, 32'hDEADBEEF);
        Read_data_Ack = 1'b1;
        @(negedge clk);
        chk("sim_iack_resp", Inst_Req_Ack, 0);
        tick();
        Read_data_Ack = 1'b0;
        chk("sim_ld_drop", Read_data_Valid, 0);
        @(negedge clk);
        chk("sim_iack_after", Inst_Req_Ack, 1);
        tick();
        Inst_Req_Valid = 1'b0;
        wait_valid(1, n);
        lat_chk("sim_fetch_lat", n);
        chk("sim_fetch_data", Instruction, 32'h00000013);
        Inst_Ack = 1'b1;
        tick();
        Inst_Ack = 1'b0;
        chk("sim_fetch_drop", Inst_Valid, 0);

        // address wrap: 0x4000 aliases word 0
        do_load(32'h4000, 32'h00000013, 0, "wrap");

        // reset during D_WAIT drops the load
        Address = 32'h100; MemRead = 1'b1;
        @(negedge clk);
        chk("mid_ack", Mem_Req_Ack, 1);
        tick();
        MemRead = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rdata_clr", Read_data, 32'h0);
        vld_seen = 0;
        repeat (20) begin
            tick();
            if (Read_data_Valid) vld_seen++;
        end
        chk("mid_no_vld", vld_seen, 0);
        do_fetch(32'h0, 32'h00000013, 0, "post_rst");

`ifdef MEM_RESP_RAND_LAT_EN
        for (int i = 0; i < 64; i++) begin
            if (i % 2 == 0) do_fetch(32'h0, 32'h00000013, 0, "rnd");
            else            do_fetch(32'h100, 32'hAA11CCDD, 0, "rnd");
        end
`else
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) do_fetch(32'h0, 32'h00000013, 0, "b2b");
            else            do_fetch(32'h100, 32'hAA11CCDD, 0, "b2b");
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_resp_unit.md
Name: mem_resp_unit

Overview:
- Memory-side responder for the multi-cycle RISC-V core's instruction and data channels.
- Accepts instruction fetches and data load/store requests over valid/ack handshakes, backed by a word-addressed on-chip array.
- Returns read data after a configurable latency and holds it until the core acknowledges.
- Used as the simulation/FPGA memory subsystem behind the core.

Parameters:
ADDR_WIDTH, 12, word-index bits; array depth = 2**ADDR_WIDTH words of 32 bits
LATENCY, 2, idle cycles between request acceptance and response valid (0..15)
LFSR_SEED, 8'hA5, nonzero seed for random latency (optional feature only)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
PC  input  32  instruction fetch byte address
Inst_Req_Valid  input  1  fetch request valid
Inst_Req_Ack  output  1  fetch request accepted
Instruction  output  32  fetched word
Inst_Valid  output  1  fetch response valid
Inst_Ack  input  1  core accepts fetch response
Address  input  32  data byte address (core supplies word-aligned)
MemWrite  input  1  store request valid
Write_data  input  32  store data (lanes pre-replicated by core)
Write_strb  input  4  byte enables for store
MemRead  input  1  load request valid
Mem_Req_Ack  output  1  load/store request accepted
Read_data  output  32  loaded word
Read_data_Valid  output  1  load response valid
Read_data_Ack  input  1  core accepts load response

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE, latency counter 0. Inst_Valid=0, Read_data_Valid=0, Instruction=0, Read_data=0. Inst_Req_Ack and Mem_Req_Ack are forced 0 while rst=0. Array contents are not cleared.
- Reset mid-operation: any pending request is dropped; no response is issued afterwards.
- Word index = addr[ADDR_WIDTH+1:2]. Upper bits are ignored, so out-of-range addresses alias (wrap). addr[1:0] is ignored.
- States: IDLE, I_WAIT, I_RESP, D_WAIT, D_RESP.
- IDLE ack generation: acks are combinational from state and request valids. Mem_Req_Ack = MemRead|MemWrite. Inst_Req_Ack = Inst_Req_Valid & ~(MemRead|MemWrite). Data has priority when both are presented; the loser keeps waiting, with no ack.
- IDLE, store accepted: bytes with Write_strb[i]=1 are written at that edge; the state stays IDLE. Strb 0000 writes nothing. Store to read latency is 0: the next request sees the new data.
- IDLE, load or fetch accepted: latch the word index, load the counter with LATENCY, then go to D_WAIT or I_WAIT respectively.
- x_WAIT: decrement the counter each cycle. When the counter is 0, read the array, register the result on Read_data/Instruction, and go to x_RESP with valid=1.
  - LATENCY=0 gives valid on the 2nd edge after acceptance.
  - LATENCY=N gives valid on edge N+2.
- x_RESP: valid and data are held stable until the corresponding Ack is 1 at an edge. At that edge valid drops to 0 and the state returns to IDLE. No new request is acked in the same cycle.
- Acks are 0 in every state except IDLE. Request-side signals are ignored outside IDLE.
- Inst_Ack high while no response is pending (e.g. the core's INIT state) is ignored.
- At most one outstanding transaction.

Optional Feature:
- Macro MEM_RESP_RAND_LAT_EN.
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4), seeded with LFSR_SEED at reset, steps every cycle. At each read acceptance the counter is loaded with LATENCY + lfsr[2:0], giving an extra 0..7 cycles.
- Undefined: the LFSR is absent and latency is exactly LATENCY.

Test Plan:
- Reset then fetch: preload word 0 = 32'h00000013. Hold rst=0 3 cycles, release, raise Inst_Req_Valid with PC=0 -> Inst_Req_Ack same cycle; Inst_Valid=1 with Instruction=32'h00000013 exactly 4 edges later (LATENCY=2); held until Inst_Ack.
- Store/load strobes: store Address=0x100, Write_data=32'hAABBCCDD, strb 1111; then store 8'h11 replicated, strb 0100 -> load 0x100 returns 32'hAA11CCDD.
- Backpressure: load response with Read_data_Ack held 0 for 5 cycles -> Read_data_Valid and Read_data stable all 5 cycles, drop the cycle after ack.
- Simultaneous requests: MemRead and Inst_Req_Valid both 1 in IDLE -> only Mem_Req_Ack=1; after the load completes, the fetch is acked.
- Wrap and reset mid-op: load Address=0x4000 (ADDR_WIDTH=12) returns word 0. Assert rst=0 during D_WAIT -> no Read_data_Valid ever; next fetch behaves normally.
- Random latency (MEM_RESP_RAND_LAT_EN): 64 back-to-back fetches -> every latency in 2..9 cycles from ack, data always correct.
